// File: rtl/ctrl_pkg.sv
// ctrl_pkg
//   Shared definitions for the exposure-time path: sequencer state encoding,
//   default exposure limits (also used by the exposure-time register) and the
//   exposure clamp helper.
package ctrl_pkg;

    typedef enum logic [1:0] {
        EX_IDLE   = 2'd0,
        EX_ERASE  = 2'd1,
        EX_EXPOSE = 2'd2,
        EX_DONE   = 2'd3
    } ex_state_t;

    localparam int          EX_W_DEF   = 5;
    localparam int unsigned EX_MIN_DEF = 2;
    localparam int unsigned EX_MAX_DEF = 30;

    // Saturate a requested exposure into [lo, hi].
    function automatic int unsigned ex_clamp(input int unsigned v,
                                             input int unsigned lo,
                                             input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/ctrl_ex_downcnt.sv
// ctrl_ex_downcnt
//   Loadable down-counter that saturates at zero.
//   Ports:
//     clk      in   rising-edge clock
//     reset    in   asynchronous active-low reset (clears value)
//     load     in   load load_val (has priority over dec)
//     load_val in   W   value to load
//     dec      in   decrement by one when value is non-zero
//     value    out  W   current count
//     is_one   out  value == 1 (terminal count)
module ctrl_ex_downcnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         is_one
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign is_one = (value == W'(1));

endmodule

// File: rtl/ctrl_ex_countdown.sv
// ctrl_ex_countdown
//   Exposure sequencer: on an accepted init it latches the clamped exposure
//   length, holds erase for ERASE_CYCLES, holds expose for the exposure length,
//   then pulses ex_done for one cycle.
//   Ports:
//     clk      in   rising-edge clock
//     reset    in   asynchronous active-low reset
//     init     in   start request, ignored while busy
//     ex_init  in   EX_W requested exposure length in cycles
//     abort    in   cancel running sequence (only when CTRL_EX_ABORT_EN is defined)
//     erase    out  high during ERASE
//     expose   out  high during EXPOSE
//     ex_done  out  one-cycle pulse in DONE
//     busy     out  high outside IDLE
//     ex_left  out  EX_W remaining exposure cycles incl. current, 0 outside EXPOSE
//   Build option: define CTRL_EX_ABORT_EN to add the abort port.
//
//   state     | meaning
//   EX_IDLE   | waiting for init
//   EX_ERASE  | erase held high, ecnt counting down
//   EX_EXPOSE | expose held high, cnt counting down
//   EX_DONE   | ex_done pulse, returns to IDLE
module ctrl_ex_countdown
    import ctrl_pkg::*;
#(
    parameter int          EX_W         = EX_W_DEF,
    parameter int unsigned EX_MIN       = EX_MIN_DEF,
    parameter int unsigned EX_MAX       = EX_MAX_DEF,
    parameter int unsigned ERASE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init,
    input  logic [EX_W-1:0] ex_init,
`ifdef CTRL_EX_ABORT_EN
    input  logic            abort,
`endif
    output logic            erase,
    output logic            expose,
    output logic            ex_done,
    output logic            busy,
    output logic [EX_W-1:0] ex_left
);

    localparam int EC_W = (ERASE_CYCLES < 2) ? 1 : $clog2(ERASE_CYCLES + 1);

    ex_state_t       state;
    logic            accept;
    logic            abort_req;
    logic [EX_W-1:0] cnt_load;
    logic [EX_W-1:0] cnt_val;
    logic            cnt_is_one;
    logic [EC_W-1:0] ecnt_val;
    logic            ecnt_is_one;
    logic            dec_cnt;
    logic            dec_ecnt;

`ifdef CTRL_EX_ABORT_EN
    assign abort_req = abort && ((state == EX_ERASE) || (state == EX_EXPOSE));
`else
    assign abort_req = 1'b0;
`endif

    assign accept   = (state == EX_IDLE) && init;
    assign cnt_load = EX_W'(ex_clamp(32'(ex_init), EX_MIN, EX_MAX));
    assign dec_ecnt = (state == EX_ERASE) && (ecnt_val != '0);
    assign dec_cnt  = (state == EX_EXPOSE);

    ctrl_ex_downcnt #(.W(EC_W)) u_ecnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (EC_W'(ERASE_CYCLES)),
        .dec      (dec_ecnt),
        .value    (ecnt_val),
        .is_one   (ecnt_is_one)
    );

    ctrl_ex_downcnt #(.W(EX_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (cnt_load),
        .dec      (dec_cnt),
        .value    (cnt_val),
        .is_one   (cnt_is_one)
    );

    // Outputs are produced alongside the state so each one is a flop that
    // already reflects the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EX_IDLE;
            erase   <= 1'b0;
            expose  <= 1'b0;
            ex_done <= 1'b0;
            busy    <= 1'b0;
            ex_left <= '0;
        end else if (abort_req) begin
            state   <= EX_IDLE;
            erase   <= 1'b0;
            expose  <= 1'b0;
            ex_done <= 1'b0;
            busy    <= 1'b0;
            ex_left <= '0;
        end else begin
            case (state)
                EX_IDLE: begin
                    if (init) begin
                        state <= EX_ERASE;
                        erase <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                EX_ERASE: begin
                    if (ecnt_is_one) begin
                        state   <= EX_EXPOSE;
                        erase   <= 1'b0;
                        expose  <= 1'b1;
                        ex_left <= cnt_val;
                    end
                end
                EX_EXPOSE: begin
                    if (cnt_is_one) begin
                        state   <= EX_DONE;
                        expose  <= 1'b0;
                        ex_done <= 1'b1;
                        ex_left <= '0;
                    end else begin
                        // Mirror the decrement the counter performs on this edge.
                        ex_left <= cnt_val - EX_W'(1);
                    end
                end
                EX_DONE: begin
                    state   <= EX_IDLE;
                    ex_done <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= EX_IDLE;
                    erase   <= 1'b0;
                    expose  <= 1'b0;
                    ex_done <= 1'b0;
                    busy    <= 1'b0;
                    ex_left <= '0;
                end
            endcase
        end
    end

endmodule
